murmur3_stream: RTL and testbench

//  Sequential MurmurHash3 (x86_32) engine over a variable-length message streamed as 32-bit words.
//  It extends the one-word combinational hash to multi-word messages: per-word body mix, tail-byte mix,

---
 rtl/murmur3_stream.sv | 151 +++++++++++++++
 tb/tb_murmur3_stream.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/murmur3_stream.sv
// murmur3_stream: sequential MurmurHash3 (x86_32) over a message streamed
// as little-endian 32-bit words. Body words and the tail are mixed as they
// are accepted, then the byte length is folded in and fmix32 runs over
// three cycles. Only one message is in flight at a time.
//
// Handshake: a beat transfers on a rising edge where s_valid && s_ready,
// and a result transfers on a rising edge where m_valid && m_ready. Once
// m_valid rises, m_valid and m_hash hold until the result transfers. A
// source may keep s_valid high while s_ready is low.
module murmur3_stream #(
   parameter int LEN_W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] seed,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] s_data,
   input  logic [2:0]  s_bytes,
   input  logic        s_last,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_hash
);

   localparam logic [31:0] C1    = 32'hCC9E2D51;
   localparam logic [31:0] C2    = 32'h1B873593;
   localparam logic [31:0] F1    = 32'h85EBCA6B;
   localparam logic [31:0] F2    = 32'hC2B2AE35;
   localparam logic [31:0] H_ADD = 32'hE6546B64;

   typedef enum logic [2:0] {
      ST_FIRST,
      ST_BODY,
      ST_FIN0,
      ST_FIN1,
      ST_FIN2,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        h_q, h_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               m_valid_q, m_valid_d;
   logic [31:0]        m_hash_q, m_hash_d;

   logic               beat;
   logic [2:0]         n;
   logic [31:0]        mask;
   logic [31:0]        h_in;
   logic [31:0]        k1, k2, k3;
   logic [31:0]        hx, hr, hb;
   logic [31:0]        h_mix;
   logic [LEN_W-1:0]   len_base;
   logic [31:0]        f0a, f0b, f1a, f1b, f2a, f2b;

   assign s_ready = (state_q == ST_FIRST) || (state_q == ST_BODY);
   assign beat    = s_valid && s_ready;
   assign m_valid = m_valid_q;
   assign m_hash  = m_hash_q;

   // Per-beat body/tail mix of the incoming word into the running hash.
   always_comb begin
      n = 3'd4;
      if (s_last && (s_bytes < 3'd4)) n = s_bytes;
      case (n)
         3'd1:    mask = 32'h0000_00FF;
         3'd2:    mask = 32'h0000_FFFF;
         3'd3:    mask = 32'h00FF_FFFF;
         default: mask = 32'hFFFF_FFFF;
      endcase
      h_in = (state_q == ST_FIRST) ? seed : h_q;
      k1   = (s_data & mask) * C1;
      k2   = {k1[16:0], k1[31:17]};
      k3   = k2 * C2;
      hx   = h_in ^ k3;
      hr   = {hx[18:0], hx[31:19]};
      hb   = hr * 32'd5 + H_ADD;
      if (n == 3'd4)      h_mix = hb;
      else if (n == 3'd0) h_mix = h_in;
      else                h_mix = hx;
      len_base = (state_q == ST_FIRST) ? '0 : len_q;
   end

   // fmix32 stages, one per finalisation state.
   always_comb begin
      f0a = h_q ^ 32'(len_q);
      f0b = f0a ^ (f0a >> 16);
      f1a = h_q * F1;
      f1b = f1a ^ (f1a >> 13);
      f2a = h_q * F2;
      f2b = f2a ^ (f2a >> 16);
   end

   // Next-state logic for the sequencer and all datapath registers.
   always_comb begin
      state_d   = state_q;
      h_d       = h_q;
      len_d     = len_q;
      m_valid_d = m_valid_q;
      m_hash_d  = m_hash_q;
      case (state_q)
         ST_FIRST, ST_BODY: begin
            if (beat) begin
               h_d     = h_mix;
               len_d   = len_base + LEN_W'(n);
               state_d = s_last ? ST_FIN0 : ST_BODY;
            end
         end
         ST_FIN0: begin
            h_d     = f0b;
            state_d = ST_FIN1;
         end
         ST_FIN1: begin
            h_d     = f1b;
            state_d = ST_FIN2;
         end
         ST_FIN2: begin
            h_d       = f2b;
            m_hash_d  = f2b;
            m_valid_d = 1'b1;
            state_d   = ST_DONE;
         end
         ST_DONE: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               state_d   = ST_FIRST;
            end
         end
         default: state_d = ST_FIRST;
      endcase
   end

   // State registers; asynchronous reset discards any partial message.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FIRST;
         h_q       <= '0;
         len_q     <= '0;
         m_valid_q <= 1'b0;
         m_hash_q  <= '0;
      end else begin
         state_q   <= state_d;
         h_q       <= h_d;
         len_q     <= len_d;
         m_valid_q <= m_valid_d;
         m_hash_q  <= m_hash_d;
      end
   end

endmodule

// File: tb/tb_murmur3_stream.sv
// tb_murmur3_stream: directed vectors for murmur3_stream with a result
// scoreboard, latency/throughput timing, backpressure and mid-message reset.
module tb_murmur3_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] seed = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic [2:0]  s_bytes = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_hash;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] msg_w[8];

  murmur3_stream #(.LEN_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .seed(seed),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_bytes(s_bytes), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_hash(m_hash)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // scoreboard: compare each result as it transfers
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) check_eq("spurious_m_valid", 32'd1, 32'd0);
      else check_eq("m_hash", m_hash, exp_q.pop_front());
    end
  end

  // drive one beat and return once it has been accepted (cycle of accept in t)
  task automatic drive_beat(input logic [31:0] d, input logic [2:0] b, input logic l, output int t);
    int waited = 0;
    s_data = d; s_bytes = b; s_last = l; s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) check_eq("s_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    t = cyc;
  endtask

  // send msg_w[0..nw-1]; seed is scrambled after the first beat and s_bytes
  // is randomised on non-last beats, neither of which may affect the hash
  task automatic send_msg(input logic [31:0] sd, input int nw, input logic [2:0] last_b,
                          input logic [31:0] exp, output int t_first, output int t_last);
    int t;
    exp_q.push_back(exp);
    t_first = 0;
    for (int i = 0; i < nw; i++) begin
      seed = (i == 0) ? sd : $urandom;
      if (i == nw - 1) drive_beat(msg_w[i], last_b, 1'b1, t);
      else drive_beat(msg_w[i], 3'($urandom_range(0, 7)), 1'b0, t);
      if (i == 0) t_first = t;
    end
    t_last = t;
    s_valid = 1'b0;
    seed = $urandom;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic one_beat(input logic [31:0] sd, input logic [31:0] d, input logic [2:0] b,
                          input logic [31:0] exp);
    int tf, tl;
    msg_w[0] = d;
    send_msg(sd, 1, b, exp, tf, tl);
    wait_drain();
  endtask

  initial begin
    int tf, tl, n;
    logic [31:0] held;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_hash", m_hash, 32'd0);
    check_eq("rst_s_ready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // empty messages
    one_beat(32'h0000_0000, 32'hDEAD_BEEF, 3'd0, 32'h0000_0000);
    one_beat(32'h0000_0001, 32'h1234_5678, 3'd0, 32'h514E_28B7);
    one_beat(32'hFFFF_FFFF, 32'h0000_0000, 3'd0, 32'h81F1_6F39);
    // single full word, plus s_bytes>4 treated as 4
    one_beat(32'h0000_0000, 32'h8765_4321, 3'd4, 32'hF55B_516B);
    one_beat(32'h5082_EDEE, 32'h8765_4321, 3'd4, 32'h2362_F9DE);
    one_beat(32'h0000_0000, 32'h8765_4321, 3'd7, 32'hF55B_516B);
    // tails, with junk in the masked-off bytes
    one_beat(32'h0000_0000, 32'h0065_4321, 3'd3, 32'h7E4A_8634);
    one_beat(32'h0000_0000, 32'hAB00_4321, 3'd2, 32'hA0F7_B07A);
    one_beat(32'h0000_0000, 32'h0000_4321, 3'd2, 32'hA0F7_B07A);
    one_beat(32'h0000_0000, 32'h5500_0021, 3'd1, 32'h7266_1CF4);

    // "Hello, world!": back-to-back body beats and 3-edge result latency
    msg_w[0] = 32'h6C6C_6548; msg_w[1] = 32'h7720_2C6F;
    msg_w[2] = 32'h646C_726F; msg_w[3] = 32'h0000_0021;
    send_msg(32'd1234, 4, 3'd1, 32'hFAF6_CDB3, tf, tl);
    check_eq("body_throughput", 32'(tl - tf), 32'd3);
    n = 0;
    while (!m_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("latency_edges", 32'(n), 32'd3);
    wait_drain();

    // backpressure: result held while m_ready low, s_valid held high meanwhile
    m_ready = 1'b0;
    msg_w[0] = 32'h8765_4321;
    send_msg(32'h0, 1, 3'd4, 32'hF55B_516B, tf, tl);
    s_valid = 1'b1; s_data = 32'h1111_1111; s_bytes = 3'd0; s_last = 1'b1; seed = 32'h0000_0001;
    n = 0;
    while (!m_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("bp_m_valid_rise", 32'(m_valid), 32'd1);
    check_eq("bp_hash", m_hash, 32'hF55B_516B);
    held = m_hash;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_m_valid", 32'(m_valid), 32'd1);
      check_eq("bp_m_hash", m_hash, held);
      check_eq("bp_s_ready", 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_drain();
    check_eq("bp_m_valid_fall", 32'(m_valid), 32'd0);
    check_eq("bp_hash_kept", m_hash, 32'hF55B_516B);
    one_beat(32'h0000_0001, 32'h0, 3'd0, 32'h514E_28B7);

    // reset mid-message: partial message discarded
    msg_w[0] = 32'hAAAA_5555; msg_w[1] = 32'h0F0F_F0F0;
    seed = 32'h0;
    drive_beat(msg_w[0], 3'd4, 1'b0, tl);
    drive_beat(msg_w[1], 3'd4, 1'b0, tl);
    s_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("mid_rst_m_hash", m_hash, 32'd0);
    check_eq("mid_rst_s_ready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_eq("post_rst_no_m_valid", 32'(m_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    one_beat(32'h0000_0000, 32'h8765_4321, 3'd4, 32'hF55B_516B);

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
